// File: rtl/seq_normalizer_8bit.sv
// Sequential left-normalizer: shifts an operand left one bit per clock until its
// MSB is set, then reports the result, the shift count and a barrel-shifter restore code.
module seq_normalizer_8bit #(
    parameter int WIDTH = 8,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] norm,
    output logic [CW-1:0]    count,
    output logic [CW:0]      S,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] r;
    logic [CW-1:0]    c;
    logic             accept;
    logic             shift_en;
    logic             finish;
    logic             r_is_zero;

    assign r_is_zero = (r == '0);

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        shift_en  = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (r_is_zero || r[WIDTH-1]) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end else begin
                    shift_en = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Work register and shift counter; the operand is captured only on the accepting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r <= '0;
            c <= '0;
        end else if (accept) begin
            r <= A;
            c <= '0;
        end else if (shift_en) begin
            r <= r << 1;
            c <= c + 1'b1;
        end
    end

    // Result registers change only on the edge that enters DONE and hold until the next completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            norm  <= '0;
            count <= '0;
            S     <= '0;
            zero  <= 1'b0;
        end else if (finish) begin
            if (r_is_zero) begin
                norm  <= '0;
                count <= '0;
                S     <= {1'b1, {CW{1'b0}}};
                zero  <= 1'b1;
            end else begin
                norm  <= r;
                count <= c;
                S     <= {1'b1, c};
                zero  <= 1'b0;
            end
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_normalizer_8bit.sv
// Directed bench for seq_normalizer_8bit: reset, basic vectors, ignored starts,
// mid-operation reset and an exhaustive round-trip sweep through a barrel-shifter model.
module tb_seq_normalizer_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] A;
    logic       busy;
    logic       done;
    logic [7:0] norm;
    logic [2:0] count;
    logic [3:0] S;
    logic       zero;

    int n_cmp = 0;
    int n_err = 0;

    seq_normalizer_8bit #(.WIDTH(8), .CW(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .busy  (busy),
        .done  (done),
        .norm  (norm),
        .count (count),
        .S     (S),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    // Drives one request from IDLE and measures the edge on which done rises (99 = never).
    task automatic run_op(input logic [7:0] a, output int lat, output int busy_cyc,
                          output logic [7:0] o_norm, output logic [2:0] o_count,
                          output logic [3:0] o_s, output logic o_zero);
        lat      = 99;
        busy_cyc = 0;
        @(negedge clk);
        start = 1'b1;
        A     = a;
        @(negedge clk);
        start = 1'b0;
        A     = ~a;
        if (busy) busy_cyc++;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_cyc++;
        end
        o_norm  = norm;
        o_count = count;
        o_s     = S;
        o_zero  = zero;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        A     = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)  begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (norm !== 8'h00) begin n_err++; $display("FAIL reset_norm: got %h want 00", norm); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (S !== 4'b0000)  begin n_err++; $display("FAIL reset_S: got %b want 0000", S); end
        n_cmp++; if (zero !== 1'b0)  begin n_err++; $display("FAIL reset_zero: got %b want 0", zero); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] va[4]  = '{8'h80, 8'h13, 8'h01, 8'h00};
        logic [7:0] vn[4]  = '{8'h80, 8'h98, 8'h80, 8'h00};
        logic [2:0] vc[4]  = '{3'd0, 3'd3, 3'd7, 3'd0};
        logic [3:0] vs[4]  = '{4'b1000, 4'b1011, 4'b1111, 4'b1000};
        logic       vz[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
        int         vl[4]  = '{1, 4, 8, 1};
        int         lat, bc;
        logic [7:0] o_n;
        logic [2:0] o_c;
        logic [3:0] o_s;
        logic       o_z;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], lat, bc, o_n, o_c, o_s, o_z);
            n_cmp++; if (lat !== vl[i]) begin n_err++; $display("FAIL basic_latency A=%h: got %0d want %0d", va[i], lat, vl[i]); end
            n_cmp++; if (bc !== vl[i])  begin n_err++; $display("FAIL basic_busy A=%h: got %0d cycles want %0d", va[i], bc, vl[i]); end
            n_cmp++; if (o_n !== vn[i]) begin n_err++; $display("FAIL basic_norm A=%h: got %h want %h", va[i], o_n, vn[i]); end
            n_cmp++; if (o_c !== vc[i]) begin n_err++; $display("FAIL basic_count A=%h: got %0d want %0d", va[i], o_c, vc[i]); end
            n_cmp++; if (o_s !== vs[i]) begin n_err++; $display("FAIL basic_S A=%h: got %b want %b", va[i], o_s, vs[i]); end
            n_cmp++; if (o_z !== vz[i]) begin n_err++; $display("FAIL basic_zero A=%h: got %b want %b", va[i], o_z, vz[i]); end
            @(negedge clk);
            n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL basic_pulse A=%h: got busy/done %b want 00", va[i], {busy, done}); end
            n_cmp++; if (norm !== vn[i]) begin n_err++; $display("FAIL basic_hold A=%h: got %h want %h", va[i], norm, vn[i]); end
        end
    endtask

    task automatic test_ignored_start();
        int         done_edge = -1;
        int         n_done    = 0;
        int         busy_after = 0;
        int         lat, bc;
        logic [7:0] o_n;
        logic [2:0] o_c;
        logic [3:0] o_s;
        logic       o_z;
        @(negedge clk);
        start = 1'b1;
        A     = 8'h01;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                done_edge = k;
            end
            if (k >= 9 && busy) busy_after++;
            // Re-asserted start is sampled on edges 2, 8 and 9 (the last one while in DONE).
            start = (k == 1) || (k == 7) || (k == 8);
            A     = 8'hFF;
        end
        n_cmp++; if (done_edge !== 8) begin n_err++; $display("FAIL ignore_done_edge: got %0d want 8", done_edge); end
        n_cmp++; if (n_done !== 1)    begin n_err++; $display("FAIL ignore_done_count: got %0d want 1", n_done); end
        n_cmp++; if (busy_after !== 0) begin n_err++; $display("FAIL ignore_restart: got %0d busy cycles want 0", busy_after); end
        n_cmp++; if (count !== 3'd7)  begin n_err++; $display("FAIL ignore_count: got %0d want 7", count); end
        n_cmp++; if (norm !== 8'h80)  begin n_err++; $display("FAIL ignore_norm: got %h want 80", norm); end
        n_cmp++; if (S !== 4'b1111)   begin n_err++; $display("FAIL ignore_S: got %b want 1111", S); end
        run_op(8'h40, lat, bc, o_n, o_c, o_s, o_z);
        n_cmp++; if (lat !== 2)      begin n_err++; $display("FAIL next_latency: got %0d want 2", lat); end
        n_cmp++; if (o_c !== 3'd1)   begin n_err++; $display("FAIL next_count: got %0d want 1", o_c); end
        n_cmp++; if (o_n !== 8'h80)  begin n_err++; $display("FAIL next_norm: got %h want 80", o_n); end
        n_cmp++; if (o_s !== 4'b1001) begin n_err++; $display("FAIL next_S: got %b want 1001", o_s); end
    endtask

    task automatic test_reset_midop();
        int         activity = 0;
        int         lat, bc;
        logic [7:0] o_n;
        logic [2:0] o_c;
        logic [3:0] o_s;
        logic       o_z;
        @(negedge clk);
        start = 1'b1;
        A     = 8'h04;
        for (int k = 0; k <= 2; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 2) rst = 1'b1;
        end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)  begin n_err++; $display("FAIL midrst_done: got %b want 0", done); end
        n_cmp++; if (norm !== 8'h00) begin n_err++; $display("FAIL midrst_norm: got %h want 00", norm); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL midrst_count: got %0d want 0", count); end
        n_cmp++; if (S !== 4'b0000)  begin n_err++; $display("FAIL midrst_S: got %b want 0000", S); end
        n_cmp++; if (zero !== 1'b0)  begin n_err++; $display("FAIL midrst_zero: got %b want 0", zero); end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) activity++;
        end
        n_cmp++; if (activity !== 0) begin n_err++; $display("FAIL midrst_idle: got %0d active cycles want 0", activity); end
        run_op(8'h20, lat, bc, o_n, o_c, o_s, o_z);
        n_cmp++; if (lat !== 3)       begin n_err++; $display("FAIL after_rst_latency: got %0d want 3", lat); end
        n_cmp++; if (o_c !== 3'd2)    begin n_err++; $display("FAIL after_rst_count: got %0d want 2", o_c); end
        n_cmp++; if (o_n !== 8'h80)   begin n_err++; $display("FAIL after_rst_norm: got %h want 80", o_n); end
        n_cmp++; if (o_s !== 4'b1010) begin n_err++; $display("FAIL after_rst_S: got %b want 1010", o_s); end
    endtask

    task automatic test_sweep();
        int         lat, bc, lz;
        logic [7:0] a, o_n, restored;
        logic [2:0] o_c;
        logic [3:0] o_s;
        logic       o_z;
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            run_op(a, lat, bc, o_n, o_c, o_s, o_z);
            // Barrel shifter: S[3]=1 selects logical right shift by S[2:0].
            restored = o_s[3] ? (o_n >> o_s[2:0]) : 8'hxx;
            lz = 0;
            if (a != 8'h00) begin
                for (int b = 7; b >= 0; b--) begin
                    if (a[b]) break;
                    lz++;
                end
            end
            n_cmp++; if (restored !== a) begin n_err++; $display("FAIL sweep_restore A=%h: got %h want %h", a, restored, a); end
            n_cmp++; if (lat !== int'(o_c) + 1) begin n_err++; $display("FAIL sweep_latency A=%h: got %0d want %0d", a, lat, int'(o_c) + 1); end
            n_cmp++; if (int'(o_c) !== lz) begin n_err++; $display("FAIL sweep_count A=%h: got %0d want %0d", a, o_c, lz); end
            n_cmp++; if (o_z !== (a == 8'h00)) begin n_err++; $display("FAIL sweep_zero A=%h: got %b want %b", a, o_z, (a == 8'h00)); end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        A     = 8'h00;
        test_reset();
        test_basic();
        test_ignored_start();
        test_reset_midop();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
